// File: rtl/dds_pkg.sv
// Shared encodings and width defaults for the DDS frequency-sweep scheduler.
package dds_pkg;

    localparam int FW_DEF = 32;
    localparam int DW_DEF = 24;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_REPEAT = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dds_sweep_step.sv
// One frequency step toward a target: FW+1-bit add/subtract, clamped so the
// word never passes the target or wraps around.
module dds_sweep_step
    import dds_pkg::*;
#(
    parameter int FW = FW_DEF
) (
    input  logic [FW-1:0] cur,
    input  logic [FW-1:0] step,
    input  logic [FW-1:0] target,
    input  logic          dir,
    output logic [FW-1:0] next,
    output logic          at_target
);

    logic [FW:0] sum_w;
    logic [FW:0] dif_w;

    // A carry or borrow out of the FW+1 result means the target was passed.
    function automatic logic [FW-1:0] clamp_up(input logic [FW:0] s, input logic [FW-1:0] t);
        return (s[FW] || (s[FW-1:0] > t)) ? t : s[FW-1:0];
    endfunction

    function automatic logic [FW-1:0] clamp_dn(input logic [FW:0] d, input logic [FW-1:0] t);
        return (d[FW] || (d[FW-1:0] < t)) ? t : d[FW-1:0];
    endfunction

    assign sum_w     = {1'b0, cur} + {1'b0, step};
    assign dif_w     = {1'b0, cur} - {1'b0, step};
    assign next      = dir ? clamp_dn(dif_w, target) : clamp_up(sum_w, target);
    // A zero step can never make progress, so it counts as already arrived.
    assign at_target = (cur == target) || (step == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: walks the DDS phase-increment word between two
// endpoints in SINGLE, REPEAT (sawtooth) or BOUNCE (triangle) mode.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_start,
    input  logic [FW-1:0] cfg_stop,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] freq_ctl,
    output logic          freq_upd,
    output logic          busy,
    output logic          done,
    output logic          sweep_dn
);

    state_e        state;
    logic [FW-1:0] sh_start, sh_stop, sh_step;
    logic [DW-1:0] sh_dwell, dwell_cnt;
    logic [1:0]    sh_mode;

    logic          dir0;
    logic [FW-1:0] tgt_fwd, tgt_rev, nxt_fwd, nxt_rev;
    logic          at_tgt, rev_at_tgt;

    assign cfg_ready = (state == ST_IDLE);
    assign dir0      = (sh_stop < sh_start);
    assign tgt_fwd   = (sweep_dn == dir0) ? sh_stop  : sh_start;
    assign tgt_rev   = (sweep_dn == dir0) ? sh_start : sh_stop;

    // The reverse stepper gives the BOUNCE turn-around value in the same edge.
    dds_sweep_step #(.FW(FW)) u_step_fwd (
        .cur(freq_ctl), .step(sh_step), .target(tgt_fwd), .dir(sweep_dn),
        .next(nxt_fwd), .at_target(at_tgt)
    );

    dds_sweep_step #(.FW(FW)) u_step_rev (
        .cur(freq_ctl), .step(sh_step), .target(tgt_rev), .dir(~sweep_dn),
        .next(nxt_rev), .at_target(rev_at_tgt)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            freq_ctl  <= '0;
            freq_upd  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_dn  <= 1'b0;
            dwell_cnt <= '0;
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_dwell  <= '0;
            sh_mode   <= '0;
        end else begin
            freq_upd <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        sh_start <= cfg_start;
                        sh_stop  <= cfg_stop;
                        sh_step  <= cfg_step;
                        sh_dwell <= cfg_dwell;
                        sh_mode  <= cfg_mode;
                    end else if (start && !abort) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        freq_ctl  <= sh_start;
                        freq_upd  <= 1'b1;
                        dwell_cnt <= sh_dwell;
                        sweep_dn  <= dir0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        dwell_cnt <= sh_dwell;
                        if (!at_tgt) begin
                            freq_ctl <= nxt_fwd;
                            freq_upd <= 1'b1;
                        end else begin
                            case (mode_e'(sh_mode))
                                MODE_REPEAT: begin
                                    freq_ctl <= sh_start;
                                    freq_upd <= 1'b1;
                                end
                                MODE_BOUNCE: begin
                                    sweep_dn <= ~sweep_dn;
                                    freq_ctl <= nxt_rev;
                                    freq_upd <= ~rev_at_tgt;
                                end
                                default: begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep scheduler that drives the `freq_ctl` input of the DDS core.
- Accepts a sweep profile over a valid/ready config port: start, stop, step, dwell and mode.
- On `start`, steps the phase-increment word from start to stop, holding each value for a programmed dwell.
- Used by the signal-generator path for chirps and swept-frequency response measurements; amplitude, phase and wave-select pass to the DDS unchanged.

Parameters:
- FW, 32, width of the frequency (phase-increment) word; matches the DDS accumulator.
- DW, 24, width of the dwell counter.

Ports:
- sys_clk  in  1  system/DAC clock.
- sys_rst  in  1  asynchronous reset, active-high.
- cfg_valid  in  1  config word presented.
- cfg_ready  out  1  block can accept config; high only in IDLE.
- cfg_start  in  FW  first frequency word.
- cfg_stop  in  FW  last frequency word.
- cfg_step  in  FW  unsigned step magnitude.
- cfg_dwell  in  DW  hold time minus one, in cycles.
- cfg_mode  in  2  0=SINGLE, 1=REPEAT (sawtooth), 2=BOUNCE (triangle), 3=reserved (treated as SINGLE).
- start  in  1  one-cycle pulse; begin sweep.
- abort  in  1  one-cycle pulse; stop sweep.
- freq_ctl  out  FW  frequency word to the DDS.
- freq_upd  out  1  one-cycle pulse whenever `freq_ctl` changes value or is reloaded.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on SINGLE-mode completion.
- sweep_dn  out  1  current direction; 1 = decreasing.

Behaviour:
- Reset values: `freq_ctl`=0, `freq_upd`=0, `busy`=0, `done`=0, `sweep_dn`=0, `cfg_ready`=1. All shadow config registers are 0, so the reset mode is SINGLE with dwell 0.
- States: IDLE, RUN, DONE. `cfg_ready` = (state==IDLE).
- Config capture:
  - In IDLE, `cfg_valid` loads all shadow registers on that edge.
  - Config is never changed in RUN or DONE; `cfg_valid` is ignored there.
- Start decode in IDLE:
  - `start` with `cfg_valid` low moves to RUN.
  - `start` together with `cfg_valid` captures the config only; `start` is ignored that cycle.
  - `start` together with `abort` does nothing.
- Sweep entry: on the edge that leaves IDLE:
  - `freq_ctl`←start and `freq_upd`=1 for the following cycle.
  - dwell counter←`cfg_dwell`.
  - base direction `dir0` = (stop < start), unsigned compare; `sweep_dn`←`dir0`.
- Dwell: every `freq_ctl` value is held exactly `cfg_dwell`+1 cycles. The counter decrements each RUN cycle; the value is updated on the edge where the counter is 0, and the counter then reloads.
- Step target: T = stop if `sweep_dn`==`dir0`, else T = start.
- Step arithmetic:
  - If `freq_ctl`≠T, next = `freq_ctl` ± step, computed FW+1 bits wide.
  - If the result passes T or wraps (carry/borrow), clamp to T. The word never wraps.
- At-target handling: if `freq_ctl`==T at dwell expiry:
  - SINGLE: go to DONE; `freq_ctl` holds.
  - REPEAT: reload start and pulse `freq_upd`.
  - BOUNCE: invert `sweep_dn` and take a step toward the new target in the same edge. Endpoints are therefore held one dwell, not two.
- Zero step (`cfg_step`==0): treated as "at target" on the first expiry.
  - SINGLE finishes after one dwell.
  - REPEAT reloads start every dwell, pulsing `freq_upd`.
  - BOUNCE holds start, toggling `sweep_dn` every dwell.
- Start equals stop: identical handling to zero step.
- DONE: lasts one cycle with `done`=1, then returns to IDLE.
- Abort:
  - In RUN or DONE, `abort` forces IDLE on the next edge.
  - `freq_ctl` holds its last value; no `done` or `freq_upd` pulse.
  - `abort` wins over a simultaneous dwell expiry.
- Outputs in IDLE: `freq_ctl` holds the last value. It is not reset by returning to IDLE.
- Reset mid-sweep: immediate return to the reset values listed above.

Decomposition:
- Shared package `dds_pkg`:
  - mode encodings (MODE_SINGLE / MODE_REPEAT / MODE_BOUNCE);
  - state enum (ST_IDLE / ST_RUN / ST_DONE);
  - FW/DW defaults.
- One combinational sub-module, `dds_sweep_step`: inputs cur, step, target and dir; outputs next and at_target. It holds the FW+1 add/subtract and the clamp, and is verified standalone.

Test Plan:
- Single up: start=100, stop=130, step=10, dwell=2, SINGLE → `freq_ctl` 100,110,120,130, each held 3 cycles; `done` one cycle after 130's last cycle; 4 `freq_upd` pulses.
- Clamp and down sweep: start=1000, stop=975, step=10, dwell=0 → 1000,990,980,975; `sweep_dn`=1; `done` follows.
- Overflow guard: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=0 → 0xFFFFFFF0 then 0xFFFFFFFF, no wrap to low values.
- Bounce: start=0, stop=20, step=10, dwell=1 → 0,10,20,10,0,10,… each held 2 cycles; `busy` stays 1; `abort` mid-run → IDLE next cycle, `freq_ctl` frozen, `done`=0.
- Repeat and config gating: REPEAT 5→7, step=1, dwell=0 → 5,6,7,5,6,7. `cfg_valid` while busy leaves the shadow unchanged. `start`+`cfg_valid` in IDLE captures config and does not start.
- Edge and reset cases: `cfg_step`=0, SINGLE, dwell=3 → start held 4 cycles, then `done`. `sys_rst` asserted mid-RUN → all outputs 0, `cfg_ready`=1, asynchronously.
